// File: rtl/conway_run_controller.sv
// Burst sequencer for a conway_cell array: holds the array in reload while idle,
// runs a requested number of generations, and strobes capture on the final one.
module conway_run_controller #(
  parameter int unsigned GEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [GEN_W-1:0] num_gens,
  input  logic             stop_on_extinct,
  input  logic             abort,
  input  logic             any_alive,
  output logic             ready,
  output logic             array_rst,
  output logic             array_ena,
  output logic             capture,
  output logic             done,
  output logic [GEN_W-1:0] gens_run,
  output logic             extinct
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CAPT = 2'd2
  } state_t;

  state_t           state_q;
  logic [GEN_W-1:0] cnt_q;
  logic [GEN_W-1:0] prog_q;
  logic             stop_q;
  logic             ext_flag_q;
  logic [GEN_W-1:0] gens_run_q;
  logic             extinct_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prog_q     <= '0;
      stop_q     <= 1'b0;
      ext_flag_q <= 1'b0;
      gens_run_q <= '0;
      extinct_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q      <= num_gens;
            prog_q     <= '0;
            stop_q     <= stop_on_extinct;
            ext_flag_q <= 1'b0;
            state_q    <= (num_gens == '0) ? S_CAPT : S_RUN;
          end
        end
        S_RUN: begin
          cnt_q  <= cnt_q - GEN_W'(1);
          prog_q <= prog_q + GEN_W'(1);
          // any_alive reflects the previous generation; this edge still
          // advances the array, which is harmless once it is all dead.
          if (abort) begin
            state_q <= S_IDLE;
          end else if (stop_q && !any_alive) begin
            ext_flag_q <= 1'b1;
            state_q    <= S_CAPT;
          end else if (cnt_q == GEN_W'(1)) begin
            state_q <= S_CAPT;
          end
        end
        S_CAPT: begin
          gens_run_q <= prog_q;
          extinct_q  <= ext_flag_q;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Reset forces the array into reload immediately and masks every other output.
  assign ready     = !rst && (state_q == S_IDLE);
  assign array_rst = rst || (state_q == S_IDLE);
  assign array_ena = !rst && (state_q == S_RUN);
  assign capture   = !rst && (state_q == S_CAPT);
  assign done      = capture;
  assign gens_run  = rst ? '0 : gens_run_q;
  assign extinct   = !rst && extinct_q;

endmodule

// File: tb/tb_conway_run_controller.sv
// Bench for conway_run_controller: drives a behavioural 5x5 Life grid from the
// controller outputs and compares burst outcomes with a generation-level model.
module tb_conway_run_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_gens;
  logic        stop_on_extinct;
  logic        abort;
  logic        any_alive;
  logic        ready;
  logic        array_rst;
  logic        array_ena;
  logic        capture;
  logic        done;
  logic [15:0] gens_run;
  logic        extinct;

  logic [24:0] seed;
  logic [24:0] grid;
  logic [24:0] last_cap;
  logic [15:0] prev_gens;
  logic        prev_ext;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam logic [24:0] V_BLINK = 25'h0021080;
  localparam logic [24:0] H_BLINK = 25'h0003800;
  localparam logic [24:0] SINGLE  = 25'h0001000;

  always #5 clk = ~clk;

  conway_run_controller #(.GEN_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_gens        (num_gens),
    .stop_on_extinct (stop_on_extinct),
    .abort           (abort),
    .any_alive       (any_alive),
    .ready           (ready),
    .array_rst       (array_rst),
    .array_ena       (array_ena),
    .capture         (capture),
    .done            (done),
    .gens_run        (gens_run),
    .extinct         (extinct)
  );

  function automatic logic [24:0] life(input logic [24:0] g);
    logic [24:0] nx;
    nx = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        int nb;
        nb = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr;
            int cc;
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 5 && cc >= 0 && cc < 5)
              if (g[rr*5+cc]) nb++;
          end
        end
        nx[r*5+c] = g[r*5+c] ? (nb == 2 || nb == 3) : (nb == 3);
      end
    end
    return nx;
  endfunction

  // Cell array: reload on rst, step on ena, otherwise clear.
  always @(posedge clk) begin
    if (array_rst)      grid <= seed;
    else if (array_ena) grid <= life(grid);
    else                grid <= '0;
  end
  assign any_alive = |grid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Burst length: in RUN cycle k the array shows generation k-1.
  function automatic int unsigned exp_len(input logic [24:0] s, input int unsigned n,
                                          input bit stp, output bit ext);
    logic [24:0] g;
    g = s;
    ext = 1'b0;
    for (int unsigned k = 1; k <= n; k++) begin
      if (stp && g == '0) begin
        ext = 1'b1;
        return k;
      end
      g = life(g);
    end
    return n;
  endfunction

  // Entered at a negedge with ready high; leaves at the negedge of the next ready cycle.
  task automatic run_burst(input logic [24:0] s, input int unsigned n, input bit stp,
                           input int unsigned ab, input bit noise);
    int unsigned len, enas, caps, cap_cyc, rdy_cyc, done_bad, both_off;
    bit          ext, aborted;
    logic [24:0] eg;
    len     = exp_len(s, n, stp, ext);
    aborted = (ab >= 1) && (ab <= len);
    eg = s;
    for (int unsigned i = 0; i < len; i++) eg = life(eg);
    enas = 0; caps = 0; cap_cyc = 0; rdy_cyc = 0; done_bad = 0; both_off = 0;
    check("ready_before_start", ready, 1);
    seed = s; num_gens = n[15:0]; stop_on_extinct = stp; start = 1'b1; abort = 1'b0;
    for (int unsigned c = 1; c <= len + 5; c++) begin
      @(negedge clk);
      if (array_ena) enas++;
      if (capture) begin
        caps++;
        if (cap_cyc == 0) begin
          cap_cyc  = c;
          last_cap = grid;
        end
      end
      if (done !== capture) done_bad++;
      if (!array_rst && !array_ena && !capture) both_off++;
      if (ready) begin
        rdy_cyc = c;
        break;
      end
      start = noise && !aborted && (c == 1 || c == len + 1);
      abort = (c == ab);
    end
    start = 1'b0;
    abort = 1'b0;
    check("ready_cycle", rdy_cyc, aborted ? ab + 1 : len + 2);
    check("ena_cycles", enas, aborted ? ab : len);
    check("capture_count", caps, aborted ? 0 : 1);
    check("done_eq_capture", done_bad, 0);
    check("never_both_off", both_off, 0);
    if (!aborted) begin
      check("capture_cycle", cap_cyc, len + 1);
      check("capture_grid", last_cap, eg);
      prev_gens = len[15:0];
      prev_ext  = ext;
    end
    check("gens_run", gens_run, prev_gens);
    check("extinct", extinct, prev_ext);
  endtask

  task automatic reset_mid_run();
    seed = V_BLINK; num_gens = 16'd20; stop_on_extinct = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_array_rst", array_rst, 1);
    check("rst_array_ena", array_ena, 0);
    check("rst_ready", ready, 0);
    check("rst_gens_run", gens_run, 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("post_rst_ready", ready, 1);
    check("post_rst_gens_run", gens_run, 0);
    check("post_rst_extinct", extinct, 0);
    check("post_rst_array_rst", array_rst, 1);
    prev_gens = '0;
    prev_ext  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_gens = '0;
    stop_on_extinct = 1'b0; seed = V_BLINK;
    prev_gens = '0; prev_ext = 1'b0; last_cap = '0;
    @(negedge clk);
    check("in_rst_array_rst", array_rst, 1);
    check("in_rst_capture", capture, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("reset_ready", ready, 1);
    check("reset_array_rst", array_rst, 1);
    check("reset_array_ena", array_ena, 0);
    check("reset_capture", capture, 0);
    check("reset_done", done, 0);
    check("reset_gens_run", gens_run, 0);
    check("reset_extinct", extinct, 0);
    @(negedge clk);

    run_burst(V_BLINK, 3, 1'b0, 0, 1'b0);
    check("blinker_horizontal", last_cap, H_BLINK);
    run_burst(V_BLINK, 0, 1'b0, 0, 1'b0);
    check("n0_shows_seed", last_cap, V_BLINK);
    run_burst(SINGLE, 100, 1'b1, 0, 1'b0);
    run_burst(SINGLE, 100, 1'b0, 0, 1'b0);
    run_burst(V_BLINK, 20, 1'b0, 5, 1'b0);
    run_burst(V_BLINK, 3, 1'b0, 0, 1'b1);
    run_burst(V_BLINK, 0, 1'b0, 0, 1'b1);
    reset_mid_run();

    for (int i = 0; i < 24; i++) begin
      logic [24:0]  s;
      int unsigned  n, ab, gap;
      bit           stp, noise;
      s     = ($urandom_range(0, 1) == 1) ? 25'($urandom & $urandom & $urandom)
                                          : 25'($urandom);
      n     = $urandom_range(0, 12);
      stp   = 1'($urandom);
      noise = 1'($urandom);
      ab    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 2) : 0;
      gap   = $urandom_range(0, 2);
      for (int unsigned j = 0; j < gap; j++) @(negedge clk);
      run_burst(s, n, stp, ab, noise);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
